// File: rtl/daq_frame_buffer_pkg.sv
// Shared DAQ word decode constants, FSM states and buffered-word layout for daq_frame_buffer.
package daq_frame_buffer_pkg;

  localparam int unsigned DAQ_W        = 19;
  localparam int unsigned LEN_W        = 11;
  localparam int unsigned DAQ_IDLE_BIT = 18;
  localparam logic [DAQ_W-1:0] DAQ_HDR     = 19'h0DB0A;
  localparam logic [7:0]       DAQ_TRL_TAG = 8'h3A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DROP    = 2'd2
  } fbuf_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_HDR  = 2'd1,
    W_TRL  = 2'd2,
    W_BODY = 2'd3
  } daq_kind_e;

  typedef struct packed {
    logic             last;
    logic [DAQ_W-1:0] data;
  } fbuf_word_t;

  // Idle bit wins over everything; header and trailer tag patterns are disjoint.
  function automatic daq_kind_e daq_kind(input logic [DAQ_W-1:0] w);
    if (w[DAQ_IDLE_BIT])              return W_IDLE;
    if (w == DAQ_HDR)                 return W_HDR;
    if (w[DAQ_W-1 -: 8] == DAQ_TRL_TAG) return W_TRL;
    return W_BODY;
  endfunction

endpackage

// File: rtl/daq_fbuf_ram.sv
// Simple dual-port frame RAM: synchronous write, registered read with read enable (holds when idle).
module daq_fbuf_ram
  import daq_frame_buffer_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fbuf_word_t    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output fbuf_word_t    rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  fbuf_word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/daq_frame_buffer.sv
// Frames the DAQ word stream, length-checks trailers and replays whole committed frames downstream.
// Define DAQ_BAD_FRAME_DROP_EN to discard length-mismatch frames instead of forwarding them.
module daq_frame_buffer
  import daq_frame_buffer_pkg::*;
#(
  parameter int unsigned AW        = 8,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic             clk,
  input  logic             hard_rst,
  input  logic [DAQ_W-1:0] daqp,
  output logic [DAQ_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic [7:0]       drop_cnt,
  output logic [7:0]       err_cnt
);

  localparam int unsigned CNT_W_MIN = $clog2(MAX_WORDS + 2);
  localparam int unsigned CNT_W     = (CNT_W_MIN > LEN_W) ? CNT_W_MIN : LEN_W;

  fbuf_state_e      state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    cmt_ptr_q, cmt_ptr_d;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             rd_vld_q;

  daq_kind_e        kind;
  logic             start, append, is_trl, ovf;
  logic [AW-1:0]    base;
  logic [CNT_W-1:0] cnt_next;
  logic             drop_inc, err_inc;
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  fbuf_word_t       ram_wdata;
  fbuf_word_t       ram_rdata;
  logic             rd_en, out_load;

  assign kind = daq_kind(daqp);

  // Write side: a header always restarts at cmt_ptr, so a truncated frame is rolled back implicitly.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cmt_ptr_d  = cmt_ptr_q;
    word_cnt_d = word_cnt_q;
    start      = 1'b0;
    append     = 1'b0;
    is_trl     = 1'b0;
    drop_inc   = 1'b0;
    err_inc    = 1'b0;
    ram_we     = 1'b0;

    case (state_q)
      ST_IDLE: start = (kind == W_HDR);
      ST_COLLECT: begin
        if (kind == W_HDR) begin
          start    = 1'b1;
          drop_inc = 1'b1;
        end else if (kind == W_BODY) begin
          append = 1'b1;
        end else if (kind == W_TRL) begin
          append = 1'b1;
          is_trl = 1'b1;
        end
      end
      ST_DROP: begin
        if (kind == W_HDR)      start   = 1'b1;
        else if (kind == W_TRL) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    base           = start ? cmt_ptr_q : wr_ptr_q;
    cnt_next       = start ? CNT_W'(1) : word_cnt_q + CNT_W'(1);
    ovf            = ((base + AW'(1)) == rd_ptr_q) || (cnt_next > CNT_W'(MAX_WORDS));
    ram_waddr      = base;
    ram_wdata.last = is_trl;
    ram_wdata.data = daqp;

    if (start || append) begin
      if (ovf) begin
        // Nothing left to discard once the trailer itself overflowed.
        wr_ptr_d   = cmt_ptr_q;
        word_cnt_d = '0;
        drop_inc   = 1'b1;
        state_d    = is_trl ? ST_IDLE : ST_DROP;
      end else begin
        ram_we     = 1'b1;
        wr_ptr_d   = base + AW'(1);
        word_cnt_d = cnt_next;
        state_d    = ST_COLLECT;
        if (is_trl) begin
          state_d    = ST_IDLE;
          word_cnt_d = '0;
          if (daqp[LEN_W-1:0] == cnt_next[LEN_W-1:0]) begin
            cmt_ptr_d = base + AW'(1);
          end else begin
            err_inc = 1'b1;
`ifdef DAQ_BAD_FRAME_DROP_EN
            wr_ptr_d = cmt_ptr_q;
            drop_inc = 1'b1;
`else
            cmt_ptr_d = base + AW'(1);
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hard_rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      cmt_ptr_q  <= '0;
      word_cnt_q <= '0;
      busy       <= 1'b0;
      drop_cnt   <= 8'd0;
      err_cnt    <= 8'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cmt_ptr_q  <= cmt_ptr_d;
      word_cnt_q <= word_cnt_d;
      busy       <= (state_d != ST_IDLE);
      if (drop_inc && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      if (err_inc && (err_cnt != 8'hFF))   err_cnt  <= err_cnt + 8'd1;
    end
  end

  // Read side: RAM output stage feeds the output register; each stage advances when the next frees.
  assign out_load = rd_vld_q && (!out_valid || out_ready);
  assign rd_en    = (rd_ptr_q != cmt_ptr_q) && (!rd_vld_q || out_load);

  always_ff @(posedge clk) begin
    if (hard_rst) begin
      rd_ptr_q  <= '0;
      rd_vld_q  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (rd_en)         rd_vld_q <= 1'b1;
      else if (out_load) rd_vld_q <= 1'b0;
      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= ram_rdata.data;
        out_last  <= ram_rdata.last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  daq_fbuf_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_en),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

endmodule
